// File: rtl/deserialize_pkg.sv
// deserialize_pkg: scl line conventions shared by the LCD-link serializer and deserializer.
package deserialize_pkg;
    localparam int SCL_IDLE_LOW  = 1;
    localparam int SCL_IDLE_HIGH = 0;
    function automatic logic idle_level(input int mode);
        return (mode == SCL_IDLE_LOW) ? 1'b0 : 1'b1;
    endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer plus history flop; emits a registered one-cycle pulse on the active edge.
module edge_sync #(
    parameter logic RST_VAL = 1'b0,
    parameter logic RISE    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic pulse
);
    logic s1_q, s2_q, h_q, p_q, p_d;
    always_comb p_d = RISE ? (s2_q & ~h_q) : (~s2_q & h_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_q, s2_q, h_q} <= {3{RST_VAL}};
            p_q <= 1'b0;
        end else begin
            {s1_q, s2_q, h_q} <= {d, s1_q, s2_q};
            p_q <= p_d;
        end
    end
    assign lvl   = s2_q;
    assign pulse = p_q;
endmodule

// File: rtl/deserialize.sv
// deserialize: recovers MSB-first WIDTH-bit words from an oversampled sda/scl pair into a
// one-entry output buffer with ready/acknowledge, sticky overrun and timeout frame errors.
module deserialize
    import deserialize_pkg::*;
#(
    parameter int SCL_MODE = SCL_IDLE_LOW,
    parameter int WIDTH    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic             cin,
    input  logic             reset,
    input  logic             sda,
    input  logic             scl,
    input  logic             iack,
    input  logic             clr,
    output logic [WIDTH-1:0] data,
    output logic             ordy,
    output logic             overrun,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [TW-1:0] LAST_TMO = TW'(TIMEOUT - 1);

    logic             sample_en, scl_lvl_unused;
    logic             sda1_q, sda_q;
    logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             ordy_q, ordy_d, ovr_q, ovr_d, fe_q, fe_d;

    edge_sync #(.RST_VAL(idle_level(SCL_MODE)), .RISE(SCL_MODE == SCL_IDLE_HIGH)) u_scl (
        .clk(cin), .rst_n(reset), .d(scl), .lvl(scl_lvl_unused), .pulse(sample_en)
    );

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmo_d   = (cnt_q != '0) ? tmo_q + 1'b1 : '0;
        data_d  = data_q;
        ordy_d  = ordy_q & ~iack;
        ovr_d   = ovr_q & ~clr;
        fe_d    = fe_q & ~clr;
        if (sample_en) begin
            shift_d = {shift_q[WIDTH-2:0], sda_q};
            tmo_d   = '0;
            cnt_d   = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
                if (!ordy_q || iack) begin
                    data_d = shift_d;
                    ordy_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end else if (cnt_q != '0 && tmo_q == LAST_TMO) begin
            // stalled mid-word: drop the partial word so the next burst realigns
            shift_d = '0;
            cnt_d   = '0;
            tmo_d   = '0;
            fe_d    = 1'b1;
        end
    end

    always_ff @(posedge cin or negedge reset) begin
        if (!reset) begin
            sda1_q  <= 1'b0;
            sda_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            ordy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sda1_q  <= sda;
            sda_q   <= sda1_q;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            ordy_q  <= ordy_d;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    assign data      = data_q;
    assign ordy      = ordy_q;
    assign overrun   = ovr_q;
    assign frame_err = fe_q;
endmodule

// File: doc/deserialize.md
Name: deserialize

Overview:
- Receive-side counterpart of the LCD-path serializer: recovers WIDTH-bit words from a two-wire sda/scl stream, MSB first.
- Runs on the receiver system clock `cin`. That clock oversamples the incoming scl; scl is never used as a clock.
- Presents each completed word on a one-entry output buffer with a ready/acknowledge handshake.
- Used for loopback self-test of the LCD link and for inbound serial peripherals.

Parameters:
- SCL_MODE, 1, line convention.
  - 1: scl idles low; sda is sampled on the falling scl edge.
  - 0: scl idles high; sda is sampled on the rising scl edge.
- WIDTH, 8, bits per word (2..32).
- TIMEOUT, 64, `cin` cycles of scl inactivity mid-word before the partial word is discarded (≥4).

Ports:
- cin  input  1  system clock, rising edge; frequency ≥ 4× scl frequency.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- sda  input  1  serial data, asynchronous to `cin`.
- scl  input  1  serial clock, asynchronous to `cin`.
- iack  input  1  consumer accepts `data` this cycle (meaningful only while ordy=1).
- clr  input  1  synchronous clear of the sticky error flags.
- data  output  WIDTH  received word, held stable while ordy=1.
- ordy  output  1  output buffer holds a valid word.
- overrun  output  1  sticky: a completed word was dropped because the buffer was full.
- frame_err  output  1  sticky: a partial word was discarded on timeout.

Behaviour:
- Reset (reset=0, asynchronous) drives:
  - ordy=0, data=0, overrun=0, frame_err=0;
  - bit counter=0, shift register=0, timeout counter=0;
  - both synchronizer stages and the edge-history flop to the idle scl level (SCL_MODE ? 0 : 1), and the sda synchronizer to 0.
  - Reset mid-word discards the partial word silently; frame_err is not set.
- Synchronization:
  - sda and scl each pass through a 2-flop synchronizer.
  - A third flop on synchronized scl provides edge detection.
  - sample_en is asserted for one `cin` cycle on the active edge of synchronized scl: falling if SCL_MODE=1, rising if SCL_MODE=0.
- Shifting, on a sample_en cycle:
  - shift register ← {shift[WIDTH-2:0], sda_sync}; bit counter increments.
  - Bits are MSB first, so after WIDTH samples the first sampled bit sits at data[MSB].
- Word completion: on the sample_en cycle where the bit counter = WIDTH-1, the counter wraps to 0 and then:
  - if ordy=0, or ordy=1 with iack=1 in the same cycle: data ← completed word and ordy ← 1 (ordy stays 1, with new data);
  - otherwise the word is dropped, overrun ← 1, and data/ordy are unchanged.
- Latency: ordy rises on the 4th `cin` rising edge after the final active scl edge first meets synchronizer setup (2 sync + 1 edge + 1 load).
- Handshake:
  - iack with ordy=1 and no simultaneous completion: ordy ← 0 next cycle; data keeps its last value.
  - iack while ordy=0 is ignored.
- Timeout:
  - The timeout counter runs only while the bit counter ≠ 0, and resets on every sample_en.
  - On reaching TIMEOUT-1: bit counter ← 0, shift register ← 0, frame_err ← 1.
  - If sample_en and timeout expiry coincide, sample_en wins and the counter restarts.
- Sticky flags:
  - clr=1 clears overrun and frame_err next cycle.
  - If clr coincides with a new error event, the flag ends set (set wins).
- No framing signal exists: word alignment depends solely on reset and timeout. A transmitter idle gap > TIMEOUT cycles realigns the receiver.

Decomposition:
- Shared include (with the serializer): SCL_MODE encodings (SCL_IDLE_LOW=1, SCL_IDLE_HIGH=0) and the idle-level function.
- One sub-module, `edge_sync`:
  - 2-flop synchronizer plus edge detector;
  - parameters for reset level and active edge;
  - outputs the synchronized level and a one-cycle pulse.
- It is instantiated for scl; sda uses the synchronizer level only.
- Bit counter width = $clog2(WIDTH); timeout counter width = $clog2(TIMEOUT).

Test Plan:
- Loopback: drive the serializer (WIDTH=8, SCL_MODE=1) from a `cin`/4 clock into this block. Send 0xA5 -> ordy=1 with data=0xA5 within 4 `cin` cycles of the 8th scl fall; iack -> ordy=0 next cycle.
- Back-to-back words 0x3C, 0xC3 with iack asserted the cycle ordy rises -> both received in order, overrun stays 0. Repeat with SCL_MODE=0 and WIDTH=12, words 0xABC, 0x123.
- Overrun: send 0x11, withhold iack, send 0x22 -> data stays 0x11 and overrun=1. Then iack, clr -> ordy=0, overrun=0.
- Completion coincident with iack while ordy=1 -> data switches to the new word, ordy stays 1, overrun=0.
- Timeout: send 3 bits, idle scl for TIMEOUT cycles -> frame_err=1, no ordy. Then send full word 0x5A -> data=0x5A.
- Async reset asserted mid-word after 5 bits, held for 2 cycles -> all outputs 0 immediately. Then send 0xFF -> data=0xFF, frame_err=0.
